// File: rtl/riscv_rf_mp.sv
// rtl/riscv_rf_mp.sv - parametrised multi-port RV32I register file, two-stage synchronous reads
// Define RISCV_RF_MP_BYPASS_EN to forward same-edge committed writes into the data stage.

module riscv_rf_mp #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NWR  = 1,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pd_stall_i,
  input  logic                id_stall_i,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  input  logic [NWR-1:0]      we_i,
  input  logic [NWR*AW-1:0]   wr_addr_i,
  input  logic [NWR*XLEN-1:0] wr_data_i
);

  // x0 has no storage; it is synthesised as a constant zero on the read path.
  logic [XLEN-1:0] rf [1:NREG-1];
  logic [AW-1:0]   sa [NRD];
  logic [XLEN-1:0] rd_next [NRD];
  logic [NWR-1:0]  wr_commit;

  always_comb begin
    wr_commit = '0;
    for (int j = 0; j < NWR; j++) begin
      wr_commit[j] = we_i[j] && !pd_stall_i && !id_stall_i && !rst &&
                     (wr_addr_i[j*AW +: AW] != '0);
    end
  end

  // Later write ports are evaluated last, so port 1 wins on an address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 1; r < NREG; r++) rf[r] <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        for (int j = 0; j < NWR; j++) begin
          if (wr_commit[j] && (wr_addr_i[j*AW +: AW] == AW'(r)))
            rf[r] <= wr_data_i[j*XLEN +: XLEN];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NRD; k++) sa[k] <= '0;
    end else if (!pd_stall_i) begin
      for (int k = 0; k < NRD; k++) sa[k] <= rd_addr_i[k*AW +: AW];
    end
  end

  always_comb begin
    for (int k = 0; k < NRD; k++) begin
      rd_next[k] = '0;
      for (int r = 1; r < NREG; r++) begin
        if (sa[k] == AW'(r)) rd_next[k] = rf[r];
      end
`ifdef RISCV_RF_MP_BYPASS_EN
      // A commit always targets a nonzero address, so x0 is never forwarded.
      for (int j = 0; j < NWR; j++) begin
        if (wr_commit[j] && (wr_addr_i[j*AW +: AW] == sa[k]))
          rd_next[k] = wr_data_i[j*XLEN +: XLEN];
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_o <= '0;
    end else if (!id_stall_i) begin
      for (int k = 0; k < NRD; k++) rd_data_o[k*XLEN +: XLEN] <= rd_next[k];
    end
  end

endmodule

// File: tb/tb_riscv_rf_mp.sv
// tb/tb_riscv_rf_mp.sv - scoreboard bench for riscv_rf_mp (3 read ports, 2 write ports)
// Expected outputs come from an array-level model of the register file.

module tb_riscv_rf_mp;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 3;
  localparam int NWR  = 2;
  localparam int AW   = 5;
`ifdef RISCV_RF_MP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                pd_stall_i = 1'b0;
  logic                id_stall_i = 1'b0;
  logic [NRD*AW-1:0]   rd_addr_i = '0;
  logic [NRD*XLEN-1:0] rd_data_o;
  logic [NWR-1:0]      we_i = '0;
  logic [NWR*AW-1:0]   wr_addr_i = '0;
  logic [NWR*XLEN-1:0] wr_data_i = '0;

  riscv_rf_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .rst(rst), .pd_stall_i(pd_stall_i), .id_stall_i(id_stall_i),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
    .we_i(we_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [XLEN-1:0]     m_rf [NREG];
  int                  m_sa [NRD];
  logic [NRD*XLEN-1:0] m_out;
  logic [NRD*XLEN-1:0] exp_q [$];

  task automatic chk(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [NRD*AW-1:0] ra3(input int a0, input int a1, input int a2);
    return {AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  // One clock: drive inputs, advance the model to the state after the next edge, queue it.
  task automatic step(input logic r, input logic p, input logic s, input logic [NRD*AW-1:0] ra,
                      input logic [NWR-1:0] w, input logic [NWR*AW-1:0] wa,
                      input logic [NWR*XLEN-1:0] wd);
    int a;
    bit commit;
    @(negedge clk);
    rst = r; pd_stall_i = p; id_stall_i = s; rd_addr_i = ra;
    we_i = w; wr_addr_i = wa; wr_data_i = wd;
    commit = !r && !p && !s;
    if (r) begin
      foreach (m_rf[i]) m_rf[i] = '0;
      foreach (m_sa[k]) m_sa[k] = 0;
      m_out = '0;
    end else begin
      if (!s) begin
        for (int k = 0; k < NRD; k++) begin
          m_out[k*XLEN +: XLEN] = (m_sa[k] == 0) ? '0 : m_rf[m_sa[k]];
          if (BYP && commit && m_sa[k] != 0)
            for (int j = 0; j < NWR; j++)
              if (w[j] && int'(wa[j*AW +: AW]) == m_sa[k]) m_out[k*XLEN +: XLEN] = wd[j*XLEN +: XLEN];
        end
      end
      if (commit)
        for (int j = 0; j < NWR; j++) begin
          a = int'(wa[j*AW +: AW]);
          if (w[j] && a != 0) m_rf[a] = wd[j*XLEN +: XLEN];
        end
      if (!p) for (int k = 0; k < NRD; k++) m_sa[k] = int'(ra[k*AW +: AW]);
    end
    exp_q.push_back(m_out);
  endtask

  task automatic idle(input int a0);
    step(1'b0, 1'b0, 1'b0, ra3(a0, 0, 0), '0, '0, '0);
  endtask

  // Monitor: outputs are presented every edge; compare each against the queued expectation.
  initial begin
    logic [NRD*XLEN-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        for (int k = 0; k < NRD; k++)
          chk($sformatf("rd_data_o[%0d]", k), rd_data_o[k*XLEN +: XLEN], e[k*XLEN +: XLEN]);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] u0, u1, u2;
    foreach (m_rf[i]) m_rf[i] = '0;
    foreach (m_sa[k]) m_sa[k] = 0;
    m_out = '0;

    step(1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
    idle(0);
    for (int k = 0; k < NRD; k++) chk("reset_out", rd_data_o[k*XLEN +: XLEN], '0);

    step(1'b0, 1'b0, 1'b0, ra3(0, 0, 0), 2'b01, {5'd0, 5'd5}, {32'd0, 32'hDEADBEEF});
    idle(5); idle(5); idle(5);
    chk("x5_read", rd_data_o[XLEN-1:0], 32'hDEADBEEF);

    step(1'b0, 1'b0, 1'b0, ra3(0, 0, 0), 2'b01, {5'd0, 5'd0}, {32'd0, 32'h12345678});
    step(1'b0, 1'b0, 1'b0, ra3(0, 0, 0), '0, '0, '0);
    idle(0); idle(0);
    for (int k = 0; k < NRD; k++) chk("x0_read", rd_data_o[k*XLEN +: XLEN], '0);

    idle(5);
    repeat (3) step(1'b0, 1'b1, 1'b0, ra3(6, 6, 6), '0, '0, '0);
    idle(5);
    chk("pd_stall_hold", rd_data_o[XLEN-1:0], 32'hDEADBEEF);
    step(1'b0, 1'b0, 1'b1, ra3(5, 0, 0), 2'b01, {5'd0, 5'd5}, {32'd0, 32'h1});
    step(1'b0, 1'b0, 1'b1, ra3(5, 0, 0), '0, '0, '0);
    idle(5); idle(5);
    chk("id_stall_drop", rd_data_o[XLEN-1:0], 32'hDEADBEEF);

    step(1'b0, 1'b0, 1'b0, ra3(7, 0, 0), 2'b11, {5'd7, 5'd7}, {32'h5555FFFF, 32'hAAAA0000});
    idle(7); idle(7);
    chk("dual_write", rd_data_o[XLEN-1:0], 32'h5555FFFF);

    step(1'b0, 1'b0, 1'b0, ra3(0, 0, 0), 2'b01, {5'd0, 5'd9}, {32'd0, 32'h11});
    idle(9);
    step(1'b0, 1'b0, 1'b0, ra3(9, 0, 0), 2'b10, {5'd9, 5'd0}, {32'h22, 32'd0});
    idle(9);
    chk("same_edge", rd_data_o[XLEN-1:0], BYP ? 32'h22 : 32'h11);
    idle(9);
    chk("next_load", rd_data_o[XLEN-1:0], 32'h22);

    for (int r = 1; r < NREG; r++) begin
      u0 = $urandom | 32'h1;
      step(1'b0, 1'b0, 1'b0, ra3(r, 0, 0), 2'b01, {5'd0, AW'(r)}, {32'd0, u0});
    end
    step(1'b1, 1'b1, 1'b1, ra3(3, 4, 5), 2'b11, {5'd3, 5'd4}, {32'hFFFF_FFFF, 32'hFFFF_FFFF});
    idle(1);
    for (int k = 0; k < NRD; k++) chk("reset_mid", rd_data_o[k*XLEN +: XLEN], '0);
    for (int r = 1; r < NREG; r++) idle(r);
    idle(0);
    chk("post_reset_x31", rd_data_o[XLEN-1:0], '0);

    for (int n = 0; n < 2000; n++) begin
      u0 = $urandom; u1 = $urandom; u2 = $urandom;
      step($urandom_range(149) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0,
           u0[NRD*AW-1:0], u0[31:30], u1[NWR*AW-1:0], {u2, u1 ^ u2});
    end

    @(posedge clk);
    #2;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
